spi_target_regs: RTL and testbench

SPI mode-0 target with an 8 × 8-bit register file, driven by an external SPI controller through the Tiny Tapeout dedicated inputs. It is the responding end of the pin interface: the top level routes `ui_in` bits to `sclk`/`cs_n`/`mosi` and `miso`/`miso_oe` to a `uio` pin. The register contents configure the rest of `tt_um_lditsche`, and one read-only register returns design status.

---
 rtl/spi_target_pkg.sv | 15 +
 rtl/spi_target_regs_sync_edge.sv | 32 +++
 rtl/spi_target_regs.sv | 184 ++++++++++++++++++
 tb/tb_spi_target_regs.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI mode-0 register target: FSM states and
// command-word layout.
package spi_target_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CMD_W  = 8;
  localparam int RW_BIT = 7;

endpackage

// File: rtl/spi_target_regs_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with single-cycle
// rise/fall pulses taken from the last stage and one extra registered copy.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_target_regs.sv
// SPI mode-0 target with a 2**ADDR_W x DATA_W register file; the top address
// is a read-only status window and is never written.
module spi_target_regs
  import spi_target_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sclk,
  input  logic                             cs_n,
  input  logic                             mosi,
  output logic                             miso,
  output logic                             miso_oe,
  input  logic [DATA_W-1:0]                status_i,
  output logic [(2**ADDR_W)*DATA_W-1:0]    regs_o,
  output logic                             wr_stb,
  output logic [ADDR_W-1:0]                wr_addr,
  output logic [DATA_W-1:0]                wr_data,
  output logic                             busy
);

  localparam int                NREGS    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(NREGS-1);
  localparam int                RX_W     = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int                CNT_W    = $clog2(RX_W+1);

  logic       sclk_sync, sclk_rise, sclk_fall;
  logic       cs_sync, mosi_sync;
  logic [1:0] cs_edge_unused, mosi_edge_unused, sclk_sync_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(sclk),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(cs_n),
    .sync(cs_sync), .rise(cs_edge_unused[0]), .fall(cs_edge_unused[1])
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .din(mosi),
    .sync(mosi_sync), .rise(mosi_edge_unused[0]), .fall(mosi_edge_unused[1])
  );

  assign sclk_sync_unused = {sclk_sync, 1'b0};

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        bit_cnt;
  logic [RX_W-2:0]         rx;
  logic [RX_W-1:0]         rx_ext;
  logic                    rw;
  logic [ADDR_W-1:0]       addr;
  logic [DATA_W-1:0]       tx;
  logic [DATA_W-1:0]       regs [NREGS];
  logic [SYNC_STAGES-1:0]  settle;
  logic                    armed;

  logic clr_cnt, inc_cnt, latch_cmd, commit, shift_rx, shift_tx;

  // Word including the bit arriving on the current rise.
  assign rx_ext = {rx, mosi_sync};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    clr_cnt   = 1'b0;
    inc_cnt   = 1'b0;
    latch_cmd = 1'b0;
    commit    = 1'b0;
    shift_rx  = 1'b0;
    shift_tx  = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !cs_sync) begin
          state_nx = CMD;
          clr_cnt  = 1'b1;
        end
      end
      CMD: begin
        if (cs_sync) begin
          state_nx = IDLE;
        end else if (sclk_rise) begin
          shift_rx = 1'b1;
          inc_cnt  = 1'b1;
          if (bit_cnt == CNT_W'(CMD_W-1)) begin
            latch_cmd = 1'b1;
            clr_cnt   = 1'b1;
            state_nx  = DATA;
          end
        end
      end
      DATA: begin
        if (cs_sync) begin
          state_nx = IDLE;
        end else begin
          if (sclk_rise) begin
            shift_rx = 1'b1;
            inc_cnt  = 1'b1;
            if (bit_cnt == CNT_W'(DATA_W-1)) begin
              state_nx = DONE;
              commit   = rw && (addr != TOP_ADDR);
            end
          end
          // The fall right after the last command rise must keep the MSB.
          shift_tx = sclk_fall && !rw && (bit_cnt != '0);
        end
      end
      DONE: begin
        if (cs_sync) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Frame arming: a frame may only start after cs_n has been seen high with
  // the synchroniser flushed of its reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[SYNC_STAGES-2:0], 1'b1};
      if (settle[SYNC_STAGES-1] && cs_sync) armed <= 1'b1;
      else if (state == IDLE && !cs_sync)   armed <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      rx      <= '0;
      rw      <= 1'b0;
      addr    <= '0;
      tx      <= '0;
    end else begin
      if (clr_cnt)      bit_cnt <= '0;
      else if (inc_cnt) bit_cnt <= bit_cnt + 1'b1;
      if (shift_rx) rx <= rx_ext[RX_W-2:0];
      if (latch_cmd) begin
        rw   <= rx_ext[RW_BIT];
        addr <= rx_ext[ADDR_W-1:0];
        if (!rx_ext[RW_BIT])
          tx <= (rx_ext[ADDR_W-1:0] == TOP_ADDR) ? status_i : regs[rx_ext[ADDR_W-1:0]];
      end else if (shift_tx) begin
        tx <= {tx[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Register file and write-commit outputs update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      miso_oe <= 1'b0;
    end else begin
      wr_stb  <= commit;
      miso_oe <= ~cs_sync;
      if (commit) begin
        regs[addr] <= rx_ext[DATA_W-1:0];
        wr_addr    <= addr;
        wr_data    <= rx_ext[DATA_W-1:0];
      end
    end
  end

  for (genvar n = 0; n < NREGS; n++) begin : g_flat
    assign regs_o[n*DATA_W +: DATA_W] = regs[n];
  end

  assign miso = (state == DATA && !rw) ? tx[DATA_W-1] : 1'b0;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_target_regs.sv
// Directed bench for spi_target_regs: writes, read-back, status window,
// abort, overlong frame and reset in the middle of a frame.
module tb_spi_target_regs;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int SYNC_STAGES = 2;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe, wr_stb, busy;
  logic [7:0]  status_i = 8'h00;
  logic [63:0] regs_o;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;

  int n_pass = 0;
  int n_chk  = 0;
  int wr_cnt = 0;
  logic [2:0] last_addr = '0;
  logic [7:0] last_data = '0;

  spi_target_regs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .status_i(status_i), .regs_o(regs_o),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      wr_cnt++;
      last_addr = wr_addr;
      last_data = wr_data;
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic spi_bits(input logic [31:0] word, input int nbits,
                          output logic [31:0] rxw, output logic stable,
                          output logic oe_all);
    logic b0;
    rxw = '0; stable = 1'b1; oe_all = 1'b1;
    for (int i = nbits-1; i >= 0; i--) begin
      mosi = word[i];
      repeat (H) @(negedge clk);
      b0 = miso;
      if (miso_oe !== 1'b1) oe_all = 1'b0;
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      if (i < 8 && miso !== b0) stable = 1'b0;
      if (miso_oe !== 1'b1) oe_all = 1'b0;
      rxw = {rxw[30:0], b0};
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] word, input int nbits,
                       output logic [31:0] rxw, output logic stable,
                       output logic oe_all);
    cs_n = 1'b0;
    spi_bits(word, nbits, rxw, stable, oe_all);
    repeat (H) @(negedge clk);
    cs_n = 1'b1;
    repeat (2*H) @(negedge clk);
  endtask

  logic [31:0] rxw;
  logic        stable, oe_all;
  int          wr0;

  initial begin
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_regs", regs_o, 64'h0);
    chk("rst_miso_oe", {63'h0, miso_oe}, 64'h0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_busy", {63'h0, busy}, 64'h0);
    chk("idle_wr_stb", {63'h0, wr_stb}, 64'h0);
    chk("idle_wr_addr", {61'h0, wr_addr}, 64'h0);
    chk("idle_wr_data", {56'h0, wr_data}, 64'h0);
    chk("idle_miso", {63'h0, miso}, 64'h0);
    chk("idle_miso_oe", {63'h0, miso_oe}, 64'h0);

    // Write 0x5A to register 2
    frame({16'h0, 8'h82, 8'h5A}, 16, rxw, stable, oe_all);
    chk("wr_count", wr_cnt, 1);
    chk("wr_addr", {61'h0, last_addr}, 64'h2);
    chk("wr_data", {56'h0, last_data}, 64'h5A);
    chk("wr_regs", regs_o, 64'h0000_0000_005A_0000);
    chk("wr_miso_zero", {56'h0, rxw[7:0]}, 64'h0);

    // Read back register 2
    frame({16'h0, 8'h02, 8'h00}, 16, rxw, stable, oe_all);
    chk("rd_data", {56'h0, rxw[7:0]}, 64'h5A);
    chk("rd_stable", {63'h0, stable}, 64'h1);
    chk("rd_oe", {63'h0, oe_all}, 64'h1);
    chk("rd_no_wr", wr_cnt, 1);
    chk("rd_busy_after", {63'h0, busy}, 64'h0);

    // Status window
    status_i = 8'hC3;
    frame({16'h0, 8'h07, 8'h00}, 16, rxw, stable, oe_all);
    chk("status_rd", {56'h0, rxw[7:0]}, 64'hC3);
    frame({16'h0, 8'h87, 8'hFF}, 16, rxw, stable, oe_all);
    chk("status_wr_drop", wr_cnt, 1);
    chk("status_regs", regs_o, 64'h0000_0000_005A_0000);

    // Abort after 5 data bits
    cs_n = 1'b0;
    spi_bits({19'h0, 8'h81, 5'b11111}, 13, rxw, stable, oe_all);
    repeat (H) @(negedge clk);
    cs_n = 1'b1;
    repeat (SYNC_STAGES+2) @(posedge clk);
    #1;
    chk("abort_busy", {63'h0, busy}, 64'h0);
    repeat (2*H) @(negedge clk);
    chk("abort_no_wr", wr_cnt, 1);
    chk("abort_regs", regs_o, 64'h0000_0000_005A_0000);
    frame({16'h0, 8'h81, 8'h3C}, 16, rxw, stable, oe_all);
    chk("post_abort_wr", wr_cnt, 2);
    chk("post_abort_addr", {61'h0, last_addr}, 64'h1);
    chk("post_abort_regs", regs_o, 64'h0000_0000_005A_3C00);

    // Overlong frame: extra byte ignored
    frame({8'h0, 8'h83, 8'h11, 8'hFF}, 24, rxw, stable, oe_all);
    chk("long_wr_count", wr_cnt, 3);
    chk("long_wr_data", {56'h0, last_data}, 64'h11);
    chk("long_miso_extra", {56'h0, rxw[7:0]}, 64'h0);
    chk("long_regs", regs_o, 64'h0000_0000_115A_3C00);

    // Reset in the middle of a write to register 4
    wr0 = wr_cnt;
    cs_n = 1'b0;
    spi_bits({20'h0, 8'h84, 4'b1010}, 12, rxw, stable, oe_all);
    rst = 1'b1;
    #1;
    chk("mid_rst_regs", regs_o, 64'h0);
    chk("mid_rst_busy", {63'h0, busy}, 64'h0);
    chk("mid_rst_oe", {63'h0, miso_oe}, 64'h0);
    chk("mid_rst_miso", {63'h0, miso}, 64'h0);
    chk("mid_rst_wr", {52'h0, wr_stb, wr_addr, wr_data}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    spi_bits({28'h0, 4'b0110}, 4, rxw, stable, oe_all);
    chk("mid_rst_ignored_busy", {63'h0, busy}, 64'h0);
    repeat (H) @(negedge clk);
    cs_n = 1'b1;
    repeat (2*H) @(negedge clk);
    chk("mid_rst_no_wr", wr_cnt, wr0);
    chk("mid_rst_reg4", regs_o, 64'h0);
    frame({16'h0, 8'h84, 8'h77}, 16, rxw, stable, oe_all);
    chk("after_rst_wr", wr_cnt, wr0 + 1);
    chk("after_rst_regs", regs_o, 64'h0000_0077_0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
